// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the five-stage back end: merges stage stall requests,
// sequences exception/ERTN redirects (RUN -> [DRAIN] -> FLUSH) and counts stall cycles.
module pipeline_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h1C000000,
  parameter logic [7:0]  DRAIN_LIMIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_req_if,
  input  logic        pause_req_id,
  input  logic        pause_req_ex,
  input  logic        pause_req_mem,
  input  logic        exception_valid,
  input  logic        exception_is_ertn,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  input  logic        fetch_busy,
  output logic [5:0]  pause,
  output logic        exception_flush,
  output logic        exception_commit,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] PAUSE_MEM  = 6'b011111;
  localparam logic [5:0] PAUSE_EX   = 6'b001111;
  localparam logic [5:0] PAUSE_ID   = 6'b000111;
  localparam logic [5:0] PAUSE_IF   = 6'b000011;
  localparam logic [5:0] PAUSE_NONE = 6'b000000;

  localparam logic [7:0] DRAIN_LAST = DRAIN_LIMIT - 8'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_drain_cnt;
  logic [31:0] r_target;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_stall_cycles;

  logic        w_accept;
  logic [31:0] w_accept_target;
  logic [5:0]  w_req_vec;
  logic [5:0]  w_pause;

  // The deepest requesting stage wins: it must freeze everything upstream of it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_req_vec = PAUSE_NONE;
    if (pause_req_mem)     w_req_vec = PAUSE_MEM;
    else if (pause_req_ex) w_req_vec = PAUSE_EX;
    else if (pause_req_id) w_req_vec = PAUSE_ID;
    else if (pause_req_if) w_req_vec = PAUSE_IF;
  end

  // A dcache miss in MEM blocks acceptance: the excepting instruction is not settled yet.
  assign w_accept        = (r_state == S_RUN) && exception_valid && !pause_req_mem;
  assign w_accept_target = exception_is_ertn ? era : eentry;

  always_comb begin
    w_state_next = r_state;
    w_pause      = PAUSE_NONE;
    unique case (r_state)
      S_RUN: begin
        if (w_accept) begin
          w_pause      = PAUSE_MEM;
          w_state_next = fetch_busy ? S_DRAIN : S_FLUSH;
        end else begin
          w_pause = w_req_vec;
        end
      end
      S_DRAIN: begin
        w_pause = PAUSE_MEM;
        if (!fetch_busy || (r_drain_cnt == DRAIN_LAST)) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_pause      = PAUSE_NONE;
        w_state_next = S_RUN;
      end
      default: w_state_next = S_RUN;
    endcase
    if (rst) w_pause = PAUSE_NONE;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state        <= S_RUN;
      r_drain_cnt    <= 8'd0;
      r_target       <= RESET_PC;
      r_redirect_pc  <= RESET_PC;
      r_stall_cycles <= 32'd0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 8'd1;
      else                    r_drain_cnt <= 8'd0;

      if (w_accept) r_target <= w_accept_target;

      // redirect_pc only moves on entry to FLUSH so it holds between redirects.
      if ((w_state_next == S_FLUSH) && (r_state != S_FLUSH))
        r_redirect_pc <= (r_state == S_RUN) ? w_accept_target : r_target;

      if (w_pause != PAUSE_NONE) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign pause            = w_pause;
  assign exception_flush  = (r_state == S_FLUSH) && !rst;
  assign exception_commit = (r_state == S_FLUSH) && !rst;
  assign redirect_valid   = (r_state == S_FLUSH) && !rst;
  assign redirect_pc      = r_redirect_pc;
  assign stall_cycles     = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (DRAIN_LIMIT shortened to 4).
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        pause_req_if;
  logic        pause_req_id;
  logic        pause_req_ex;
  logic        pause_req_mem;
  logic        exception_valid;
  logic        exception_is_ertn;
  logic [31:0] eentry;
  logic [31:0] era;
  logic        fetch_busy;
  logic [5:0]  pause;
  logic        exception_flush;
  logic        exception_commit;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(
    .RESET_PC    (32'h1C000000),
    .DRAIN_LIMIT (8'd4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pause_req_if      (pause_req_if),
    .pause_req_id      (pause_req_id),
    .pause_req_ex      (pause_req_ex),
    .pause_req_mem     (pause_req_mem),
    .exception_valid   (exception_valid),
    .exception_is_ertn (exception_is_ertn),
    .eentry            (eentry),
    .era               (era),
    .fetch_busy        (fetch_busy),
    .pause             (pause),
    .exception_flush   (exception_flush),
    .exception_commit  (exception_commit),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .stall_cycles      (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Clear all request inputs; callers then set what the cycle needs.
  task automatic idle();
    pause_req_if      = 1'b0;
    pause_req_id      = 1'b0;
    pause_req_ex      = 1'b0;
    pause_req_mem     = 1'b0;
    exception_valid   = 1'b0;
    exception_is_ertn = 1'b0;
    fetch_busy        = 1'b0;
  endtask

  // Inputs are driven just after posedge; checks happen at the following negedge.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flush(input string tag, input logic exp);
    check({tag, "_flush"},  {31'd0, exception_flush},  {31'd0, exp});
    check({tag, "_commit"}, {31'd0, exception_commit}, {31'd0, exp});
    check({tag, "_rvalid"}, {31'd0, redirect_valid},   {31'd0, exp});
  endtask

  initial begin
    idle();
    rst    = 1'b1;
    eentry = 32'h1C008000;
    era    = 32'h1C0000A4;
    advance();

    // Reset dominates requests.
    pause_req_mem = 1'b1;
    sample();
    check("rst_pause", {26'd0, pause}, 32'd0);
    chk_flush("rst", 1'b0);
    advance();

    idle();
    rst = 1'b0;
    sample();
    check("post_rst_stall", stall_cycles, 32'd0);
    check("post_rst_rpc", redirect_pc, 32'h1C000000);
    check("post_rst_pause", {26'd0, pause}, 32'd0);
    chk_flush("post_rst", 1'b0);
    advance();

    // Stall priority.
    pause_req_id = 1'b1; pause_req_ex = 1'b1;
    sample(); check("prio_id_ex", {26'd0, pause}, {26'd0, 6'b001111});
    advance(); idle();
    pause_req_if = 1'b1;
    sample(); check("prio_if", {26'd0, pause}, {26'd0, 6'b000011});
    advance(); idle();
    sample(); check("prio_none", {26'd0, pause}, 32'd0);
    check("stall_2", stall_cycles, 32'd2);
    advance();
    pause_req_mem = 1'b1; pause_req_if = 1'b1;
    sample(); check("prio_mem_if", {26'd0, pause}, {26'd0, 6'b011111});
    advance(); idle();
    pause_req_id = 1'b1;
    sample(); check("prio_id", {26'd0, pause}, {26'd0, 6'b000111});
    advance(); idle();
    sample(); check("stall_4", stall_cycles, 32'd4);
    advance();

    // Basic exception, idle fetch.
    exception_valid = 1'b1; eentry = 32'h1C008000; era = 32'h1C0000A4;
    sample();
    check("exc_acc_pause", {26'd0, pause}, {26'd0, 6'b011111});
    chk_flush("exc_acc", 1'b0);
    advance(); idle();
    pause_req_ex = 1'b1;
    sample();
    chk_flush("exc_fl", 1'b1);
    check("exc_fl_rpc", redirect_pc, 32'h1C008000);
    check("exc_fl_pause", {26'd0, pause}, 32'd0);
    check("stall_5", stall_cycles, 32'd5);
    advance(); idle();
    pause_req_if = 1'b1;
    sample();
    chk_flush("exc_run", 1'b0);
    check("exc_run_pause", {26'd0, pause}, {26'd0, 6'b000011});
    check("exc_hold_rpc", redirect_pc, 32'h1C008000);
    advance(); idle();

    // ERTN with fetch busy for three cycles.
    exception_valid = 1'b1; exception_is_ertn = 1'b1; fetch_busy = 1'b1;
    sample(); check("ertn_t0_pause", {26'd0, pause}, {26'd0, 6'b011111});
    advance(); idle();
    fetch_busy = 1'b1; pause_req_if = 1'b1;
    sample();
    check("ertn_t1_pause", {26'd0, pause}, {26'd0, 6'b011111});
    chk_flush("ertn_t1", 1'b0);
    check("ertn_t1_rpc", redirect_pc, 32'h1C008000);
    advance(); idle();
    fetch_busy = 1'b1; exception_valid = 1'b1;
    sample();
    check("ertn_t2_pause", {26'd0, pause}, {26'd0, 6'b011111});
    chk_flush("ertn_t2", 1'b0);
    advance(); idle();
    sample();
    check("ertn_t3_pause", {26'd0, pause}, {26'd0, 6'b011111});
    chk_flush("ertn_t3", 1'b0);
    advance();
    sample();
    chk_flush("ertn_fl", 1'b1);
    check("ertn_fl_rpc", redirect_pc, 32'h1C0000A4);
    check("ertn_fl_pause", {26'd0, pause}, 32'd0);
    check("stall_10", stall_cycles, 32'd10);
    advance();
    sample(); chk_flush("ertn_run", 1'b0);
    advance();

    // Exception blocked by dcache miss for two cycles.
    exception_valid = 1'b1; pause_req_mem = 1'b1; eentry = 32'h1C00C000;
    sample();
    check("blk_c0_pause", {26'd0, pause}, {26'd0, 6'b011111});
    chk_flush("blk_c0", 1'b0);
    advance();
    sample(); chk_flush("blk_c1", 1'b0);
    advance();
    pause_req_mem = 1'b0;
    sample();
    check("blk_acc_pause", {26'd0, pause}, {26'd0, 6'b011111});
    chk_flush("blk_acc", 1'b0);
    advance(); idle();
    sample();
    chk_flush("blk_fl", 1'b1);
    check("blk_fl_rpc", redirect_pc, 32'h1C00C000);
    check("stall_13", stall_cycles, 32'd13);
    advance();

    // Drain timeout: fetch stuck busy, FLUSH four cycles after DRAIN entry.
    exception_valid = 1'b1; fetch_busy = 1'b1; eentry = 32'h1C010000;
    sample(); check("to_acc_pause", {26'd0, pause}, {26'd0, 6'b011111});
    advance(); idle();
    fetch_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk_flush($sformatf("to_drain%0d", i), 1'b0);
      check($sformatf("to_drain%0d_pause", i), {26'd0, pause}, {26'd0, 6'b011111});
      advance();
    end
    sample();
    chk_flush("to_fl", 1'b1);
    check("to_fl_rpc", redirect_pc, 32'h1C010000);
    check("stall_18", stall_cycles, 32'd18);
    advance(); idle();
    sample(); chk_flush("to_run", 1'b0);
    advance();

    // Reset in the middle of DRAIN abandons the redirect.
    exception_valid = 1'b1; fetch_busy = 1'b1; eentry = 32'h1C020000;
    advance(); idle();
    fetch_busy = 1'b1;
    sample(); check("rd_drain_pause", {26'd0, pause}, {26'd0, 6'b011111});
    advance();
    rst = 1'b1;
    sample();
    check("rd_rst_pause", {26'd0, pause}, 32'd0);
    chk_flush("rd_rst", 1'b0);
    advance();
    rst = 1'b0; idle();
    sample();
    chk_flush("rd_after", 1'b0);
    check("rd_rpc", redirect_pc, 32'h1C000000);
    check("rd_stall", stall_cycles, 32'd0);
    check("rd_pause", {26'd0, pause}, 32'd0);
    advance();
    pause_req_id = 1'b1;
    sample(); check("rd_run_pause", {26'd0, pause}, {26'd0, 6'b000111});
    advance(); idle();
    sample();
    chk_flush("rd_run", 1'b0);
    check("rd_stall_1", stall_cycles, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the five-stage back end. It merges per-stage stall requests into the six-bit `pause` vector consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences exception and ERTN redirects: it holds MEM, drains an in-flight instruction fetch, raises a one-cycle `exception_flush` to all stage registers, and drives the redirect PC. It also keeps a stall-cycle performance counter.

## Interface
Parameters:
- `RESET_PC`, 32'h1C000000, value of `redirect_pc` after reset.
- `DRAIN_LIMIT`, 8'd255, maximum number of DRAIN cycles before FLUSH is forced.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `pause_req_if`  in  1  IF stage stall request (icache miss).
- `pause_req_id`  in  1  ID stage stall request (load-use hazard).
- `pause_req_ex`  in  1  EX stage stall request (multi-cycle mul/div).
- `pause_req_mem`  in  1  MEM stage stall request (dcache miss).
- `exception_valid`  in  1  MEM-stage instruction carries an exception or is ERTN.
- `exception_is_ertn`  in  1  qualifies `exception_valid` as ERTN.
- `eentry`  in  32  CSR exception entry address.
- `era`  in  32  CSR exception return address.
- `fetch_busy`  in  1  icache has an outstanding refill.
- `pause`  out  6  stall vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- `exception_flush`  out  1  clears all stage registers.
- `exception_commit`  out  1  one-cycle pulse to the CSR unit to commit the exception or ERTN state update.
- `redirect_valid`  out  1  PC must load `redirect_pc`.
- `redirect_pc`  out  32  redirect target.
- `stall_cycles`  out  32  performance counter.

## Operation
- States: RUN, DRAIN, FLUSH.
- **RUN, stall vector.** The highest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- **RUN, exception acceptance.** An exception is accepted when `exception_valid && !pause_req_mem`.
  - In the acceptance cycle `pause`=6'b011111, overriding the request vector.
  - At the clock edge, latch the target: `era` if `exception_is_ertn`, else `eentry`.
  - Next state is DRAIN if `fetch_busy`, else FLUSH.
- **RUN with `exception_valid && pause_req_mem`.** The exception is not accepted. `pause` follows the request vector (011111) and the state stays RUN.
- **DRAIN.**
  - `pause`=6'b011111; all stall requests are ignored.
  - `drain_cnt` increments each cycle.
  - Go to FLUSH when `!fetch_busy`, or when `drain_cnt==DRAIN_LIMIT-1` (forced).
- **FLUSH** (exactly one cycle):
  - `exception_flush`=1, `exception_commit`=1, `redirect_valid`=1, `redirect_pc`=latched target, `pause`=6'b000000.
  - Next state RUN; `drain_cnt` is cleared.
- **Exception inputs outside RUN.** `exception_valid` is ignored in DRAIN and FLUSH; there is no nesting.
- **`redirect_pc` hold.** Registered; it keeps its last value when `redirect_valid`=0.
- **`stall_cycles`.** Increments by 1 on every cycle with `pause`!=0, in any state, and wraps modulo 2^32.
- **Reset** (`rst`=1 during a cycle):
  - Next state RUN, `drain_cnt`=0, `stall_cycles`=0, `redirect_pc`=RESET_PC.
  - While `rst`=1, `pause`=0, `exception_flush`=0, `exception_commit`=0, `redirect_valid`=0.
  - Asserting `rst` in DRAIN or FLUSH abandons the redirect with no flush pulse.

## Timing
- `pause` is combinational from state and inputs in RUN, with zero latency; it is constant per state in DRAIN and FLUSH.
- `exception_flush`, `exception_commit`, `redirect_valid` and `redirect_pc` are decoded from registered state and latched target, so they are glitch-free.
- **Exception latency.** Accepted in cycle T with `fetch_busy`=0 → FLUSH in T+1 → RUN in T+2.
- **Exception with a busy fetch.** `fetch_busy` falls in cycle D → FLUSH in D+1.
- **Drain timeout.** DRAIN entered at T+1 with `fetch_busy` stuck high → FLUSH at T+1+DRAIN_LIMIT.
- **Stage-register contract.**
  - A stage register inserts a bubble when `pause[i] && !pause[i+1]`.
  - It holds when `pause[i]` and `pause[i+1]` are both set.
  - `exception_flush` has priority over `pause`.

## Test plan
- **Stall priority.** Assert `pause_req_id` and `pause_req_ex` together, then `pause_req_if` alone → `pause`=6'b001111, then 6'b000011; `stall_cycles` increments by 2.
- **Basic exception.** `exception_valid`=1, `eentry`=32'h1C008000, `fetch_busy`=0 → `pause`=011111 in the same cycle. Next cycle: `exception_flush`=`exception_commit`=`redirect_valid`=1, `redirect_pc`=32'h1C008000, `pause`=0. One cycle later: RUN.
- **ERTN with drain.** `exception_is_ertn`=1, `era`=32'h1C0000A4, `fetch_busy` high for 3 cycles → `pause`=011111 for 4 cycles, then a FLUSH with `redirect_pc`=32'h1C0000A4.
- **Exception blocked by dcache miss.** `exception_valid` and `pause_req_mem` high for 2 cycles, then `pause_req_mem` falls → no flush during the 2 cycles; accepted in the third cycle and FLUSH one cycle later.
- **Drain timeout.** `DRAIN_LIMIT`=4, `fetch_busy` stuck at 1 → FLUSH exactly 4 cycles after DRAIN entry.
- **Reset mid-DRAIN.** Assert `rst` during DRAIN → no `exception_flush` pulse; `redirect_pc`=32'h1C000000, `stall_cycles`=0, state RUN after the reset cycle.
